// File: rtl/bno085_report_parser_if.sv
// Byte stream from the BNO085 bus reader: one byte per accepted cycle, with
// a start-of-packet marker on the first SHTP header byte.
interface bno085_report_parser_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_start;

  modport master (output byte_valid, output byte_data, output frame_start);
  modport slave  (input  byte_valid, input  byte_data, input  frame_start);
endinterface

// File: rtl/bno085_report_parser.sv
// SHTP report parser: turns the BNO085 byte stream into atomic rotation-vector
// and calibrated-gyro samples with one-cycle valid pulses.
module bno085_report_parser #(
  parameter logic [7:0] CHANNEL = 8'd3,
  parameter logic [7:0] ROT_ID  = 8'h05,
  parameter logic [7:0] GYRO_ID = 8'h02,
  parameter logic [7:0] TS_ID   = 8'hFB
) (
  input  logic                    clk,
  input  logic                    rst,
  bno085_report_parser_if.slave   bus,
  output logic                    quat_valid,
  output logic signed [15:0]      quat_w,
  output logic signed [15:0]      quat_x,
  output logic signed [15:0]      quat_y,
  output logic signed [15:0]      quat_z,
  output logic                    gyro_valid,
  output logic signed [15:0]      gyro_x,
  output logic signed [15:0]      gyro_y,
  output logic signed [15:0]      gyro_z,
  output logic [7:0]              drop_count
);

  typedef enum logic [2:0] {IDLE, HDR, REPORT_ID, BODY, SKIP} state_t;
  typedef enum logic [1:0] {K_ROT, K_GYRO, K_TS} kind_t;

  state_t             state_q, state_d;
  kind_t              kind_q, kind_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         last_q, last_d;
  logic [14:0]        rem_q, rem_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [6:0]         len_hi_q, len_hi_d;
  logic [7:0]         chan_q, chan_d;
  logic signed [15:0] sx_q, sx_d, sy_q, sy_d, sz_q, sz_d, sw_q, sw_d;
  logic               quat_valid_q, quat_valid_d, gyro_valid_q, gyro_valid_d;
  logic signed [15:0] quat_w_q, quat_w_d, quat_x_q, quat_x_d;
  logic signed [15:0] quat_y_q, quat_y_d, quat_z_q, quat_z_d;
  logic signed [15:0] gyro_x_q, gyro_x_d, gyro_y_q, gyro_y_d, gyro_z_q, gyro_z_d;
  logic [7:0]         drop_q, drop_d;
  logic [14:0]        pkt_len;
  logic [7:0]         b;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Continuation bit is already stripped when the high length byte is stored.
  assign pkt_len = {len_hi_q, len_lo_q};
  assign b       = bus.byte_data;

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    rem_d        = rem_q;
    len_lo_d     = len_lo_q;
    len_hi_d     = len_hi_q;
    chan_d       = chan_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    sz_d         = sz_q;
    sw_d         = sw_q;
    quat_valid_d = 1'b0;
    gyro_valid_d = 1'b0;
    quat_w_d     = quat_w_q;
    quat_x_d     = quat_x_q;
    quat_y_d     = quat_y_q;
    quat_z_d     = quat_z_q;
    gyro_x_d     = gyro_x_q;
    gyro_y_d     = gyro_y_q;
    gyro_z_d     = gyro_z_q;
    drop_d       = drop_q;

    if (bus.byte_valid) begin
      if (bus.frame_start) begin
        // A new packet abandons any report still being collected.
        if (state_q == BODY && kind_q != K_TS) drop_d = sat_inc(drop_q);
        len_lo_d = b;
        cnt_d    = 4'd1;
        state_d  = HDR;
      end else begin
        case (state_q)
          HDR: begin
            case (cnt_q)
              4'd1: begin
                len_hi_d = b[6:0];
                cnt_d    = 4'd2;
              end
              4'd2: begin
                chan_d = b;
                cnt_d  = 4'd3;
              end
              default: begin
                cnt_d = 4'd0;
                rem_d = pkt_len - 15'd4;
                if (pkt_len < 15'd5)        state_d = IDLE;
                else if (chan_q != CHANNEL) state_d = SKIP;
                else                        state_d = REPORT_ID;
              end
            endcase
          end
          REPORT_ID: begin
            rem_d = rem_q - 15'd1;
            cnt_d = 4'd1;
            if (b == ROT_ID || b == GYRO_ID || b == TS_ID) begin
              if (b == ROT_ID) begin
                kind_d = K_ROT;
                last_d = 4'd13;
              end else if (b == GYRO_ID) begin
                kind_d = K_GYRO;
                last_d = 4'd9;
              end else begin
                kind_d = K_TS;
                last_d = 4'd4;
              end
              if (rem_q == 15'd1) begin
                if (b != TS_ID) drop_d = sat_inc(drop_q);
                state_d = IDLE;
              end else begin
                state_d = BODY;
              end
            end else begin
              drop_d  = sat_inc(drop_q);
              state_d = (rem_q == 15'd1) ? IDLE : SKIP;
            end
          end
          BODY: begin
            rem_d = rem_q - 15'd1;
            cnt_d = cnt_q + 4'd1;
            case (cnt_q)
              4'd4:    sx_d[7:0]  = b;
              4'd5:    sx_d[15:8] = b;
              4'd6:    sy_d[7:0]  = b;
              4'd7:    sy_d[15:8] = b;
              4'd8:    sz_d[7:0]  = b;
              4'd9:    sz_d[15:8] = b;
              4'd10:   sw_d[7:0]  = b;
              4'd11:   sw_d[15:8] = b;
              default: ;
            endcase
            if (cnt_q == last_q) begin
              // Commit from the next-shadow values so the final field byte lands too.
              if (kind_q == K_ROT) begin
                quat_x_d     = sx_d;
                quat_y_d     = sy_d;
                quat_z_d     = sz_d;
                quat_w_d     = sw_d;
                quat_valid_d = 1'b1;
              end else if (kind_q == K_GYRO) begin
                gyro_x_d     = sx_d;
                gyro_y_d     = sy_d;
                gyro_z_d     = sz_d;
                gyro_valid_d = 1'b1;
              end
              state_d = (rem_q == 15'd1) ? IDLE : REPORT_ID;
            end else if (rem_q == 15'd1) begin
              if (kind_q != K_TS) drop_d = sat_inc(drop_q);
              state_d = IDLE;
            end
          end
          SKIP: begin
            rem_d = rem_q - 15'd1;
            if (rem_q == 15'd1) state_d = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      kind_q       <= K_ROT;
      cnt_q        <= '0;
      last_q       <= '0;
      rem_q        <= '0;
      len_lo_q     <= '0;
      len_hi_q     <= '0;
      chan_q       <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      sz_q         <= '0;
      sw_q         <= '0;
      quat_valid_q <= 1'b0;
      gyro_valid_q <= 1'b0;
      quat_w_q     <= '0;
      quat_x_q     <= '0;
      quat_y_q     <= '0;
      quat_z_q     <= '0;
      gyro_x_q     <= '0;
      gyro_y_q     <= '0;
      gyro_z_q     <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      rem_q        <= rem_d;
      len_lo_q     <= len_lo_d;
      len_hi_q     <= len_hi_d;
      chan_q       <= chan_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      sz_q         <= sz_d;
      sw_q         <= sw_d;
      quat_valid_q <= quat_valid_d;
      gyro_valid_q <= gyro_valid_d;
      quat_w_q     <= quat_w_d;
      quat_x_q     <= quat_x_d;
      quat_y_q     <= quat_y_d;
      quat_z_q     <= quat_z_d;
      gyro_x_q     <= gyro_x_d;
      gyro_y_q     <= gyro_y_d;
      gyro_z_q     <= gyro_z_d;
      drop_q       <= drop_d;
    end
  end

  assign quat_valid = quat_valid_q;
  assign quat_w     = quat_w_q;
  assign quat_x     = quat_x_q;
  assign quat_y     = quat_y_q;
  assign quat_z     = quat_z_q;
  assign gyro_valid = gyro_valid_q;
  assign gyro_x     = gyro_x_q;
  assign gyro_y     = gyro_y_q;
  assign gyro_z     = gyro_z_q;
  assign drop_count = drop_q;

endmodule
